out_dev_fifo: RTL and testbench
===============================

# out_dev_fifo

Parametrised memory-mapped output device for the MIPS CPU data bus, the successor to the two-register output device. It provides NREG read/write holding registers plus a buffered transmit channel: CPU stores to the TX word enter a DEPTH-entry FIFO, which drains to an external consumer over a valid/ready handshake. A status word exposes occupancy and a sticky overflow flag. An optional level interrupt signals that the FIFO has drained to a threshold.

## Interface
- WIDTH, 32: data width of bus and FIFO entries; must be ≥ 20.
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- NREG, 2: number of plain holding registers, ≥ 1.
- ADDR_W, 3: word-address width; must satisfy 2^ADDR_W ≥ NREG+3.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  bus write enable for the current cycle.
- addr  in  ADDR_W  word address (byte address bits [ADDR_W+1:2]).
- din  in  WIDTH  write data.
- dout  out  WIDTH  combinational read data for addr.
- tx_data  out  WIDTH  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data this cycle.
- irq  out  1  drain interrupt; present only with OUT_DEV_IRQ_EN.

## Operation
- Register map (word address): 0..NREG-1 HOLD[i] R/W; NREG TX (write pushes; read returns last accepted push); NREG+1 STATUS; NREG+2 IRQCFG (macro only). All other addresses read 0 and ignore writes.
- CW = log2(DEPTH)+1. STATUS: [CW-1:0] count, [16] empty, [17] full, [18] overflow, [19] irq; other bits 0.
- Write to STATUS with din[18]=1 clears overflow; other STATUS bits are read-only.
- pop = tx_valid && tx_ready. push_req = en && addr==NREG.
- Push accepted iff count<DEPTH or pop in the same cycle; accepted word is written at the tail and the TX readback register is updated.
- Rejected push (full, no simultaneous pop): data dropped, count unchanged, overflow set. Set wins over a same-cycle clear.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- First-word-fall-through: tx_data = entry at head; tx_valid = (count≠0). tx_data is don't-care while tx_valid=0; bench must not check it.
- tx_ready while empty has no effect.

## Timing
- Reset values: HOLD[*]=0, TX readback=0, count=0, pointers=0, overflow=0, IRQCFG=0, tx_valid=0, irq=0; dout reflects these combinationally.
- Register writes take effect at the write edge; dout shows new value from the next cycle.
- Push-to-tx_valid latency: 1 cycle (push at edge N, tx_valid high after edge N).
- Pop removes the head at the edge; next word is on tx_data after that edge.
- Reset asserted mid-transfer discards all FIFO contents; tx_valid drops immediately, without waiting for a clock edge.

## Configuration
- OUT_DEV_IRQ_EN defined: IRQCFG is implemented as follows: [0] ie, [CW+7:8] threshold; all other bits read 0. irq is a registered level: irq is high after the edge at which ie=1 and count ≤ threshold holds, and low after the edge at which that condition fails. STATUS[19] mirrors irq.
- OUT_DEV_IRQ_EN undefined: no irq port; address NREG+2 reads 0 and ignores writes; STATUS[19] reads 0.

## Test plan
- Reset, then write HOLD[0]=0x1234_5678 and HOLD[1]=0xCAFE_0001 -> readback matches exactly; STATUS = 0x0001_0000 (empty).
- Push 3 words with tx_ready=0 -> count=3, tx_valid=1, tx_data equals the first word; raise tx_ready for 3 cycles -> words emerge in order, and empty=1 after the third.
- Push DEPTH+1 words with tx_ready=0 -> full=1, overflow=1, 9th word dropped; write STATUS din[18]=1 -> overflow=0.
- Hold FIFO full with tx_ready=1 and push every cycle -> every push accepted, count stays DEPTH, overflow stays 0, output order preserved across pointer wrap.
- Assert reset with count=5 -> tx_valid=0 and count=0 immediately, before any clock edge; the first push after reset appears alone.
- (OUT_DEV_IRQ_EN) IRQCFG ie=1, threshold=2; push 4, drain -> irq rises after the edge at which count becomes 2 and stays high while count ≤ 2; clearing ie drops irq after the next edge.

Source files
------------

// File: rtl/out_dev_fifo_if.sv
// CPU data-bus and transmit-stream signals of out_dev_fifo.
// The CPU/consumer side uses master; the device uses slave.
interface out_dev_fifo_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic [WIDTH-1:0]  tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output en, addr, din, tx_ready, input dout, tx_data, tx_valid);
  modport slave  (input en, addr, din, tx_ready, output dout, tx_data, tx_valid);
endinterface

// File: rtl/out_dev_fifo.sv
// Memory-mapped output device: NREG holding registers, TX FIFO with valid/ready drain, status word.
// Define OUT_DEV_IRQ_EN to add the IRQCFG register and the drain-threshold irq output.
module out_dev_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int NREG   = 2,
  parameter int ADDR_W = 3
) (
  input  logic clk,
  input  logic reset,
  out_dev_fifo_if.slave bus
`ifdef OUT_DEV_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(NREG);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NREG + 1);
  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(NREG + 2);

  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] hold [NREG];
  logic [WIDTH-1:0] tx_last;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             overflow;
  logic             irq_q;
  logic             pop, push_req, push_ok;
  logic [WIDTH-1:0] rdata;

  assign pop      = (count != '0) && bus.tx_ready;
  assign push_req = bus.en && (bus.addr == A_TX);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((count != CW'(DEPTH)) || pop);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + CW'(1);
    else if (!push_ok && pop) count_nxt = count - CW'(1);
  end

  // NOTE: the storage array has no reset; count=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) hold[i] <= '0;
      tx_last  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (bus.en && bus.addr == ADDR_W'(i)) hold[i] <= bus.din;
      if (push_ok) begin
        wr_ptr  <= wr_ptr + PW'(1);
        tx_last <= bus.din;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (bus.en && bus.addr == A_STAT && bus.din[18])
        overflow <= 1'b0;
    end
  end

`ifdef OUT_DEV_IRQ_EN
  logic          ie, ie_nxt, cfg_wr;
  logic [CW-1:0] thr, thr_nxt;

  assign cfg_wr  = bus.en && (bus.addr == A_CFG);
  assign ie_nxt  = cfg_wr ? bus.din[0] : ie;
  assign thr_nxt = cfg_wr ? bus.din[CW+7:8] : thr;

  // irq is evaluated on post-edge state so it tracks the count it reports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie    <= 1'b0;
      thr   <= '0;
      irq_q <= 1'b0;
    end else begin
      ie    <= ie_nxt;
      thr   <= thr_nxt;
      irq_q <= ie_nxt && (count_nxt <= thr_nxt);
    end
  end

  assign irq = irq_q;
`else
  assign irq_q = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++)
      if (bus.addr == ADDR_W'(i)) rdata = hold[i];
    if (bus.addr == A_TX) rdata = tx_last;
    if (bus.addr == A_STAT) begin
      rdata[CW-1:0] = count;
      rdata[16]     = (count == '0);
      rdata[17]     = (count == CW'(DEPTH));
      rdata[18]     = overflow;
      rdata[19]     = irq_q;
    end
`ifdef OUT_DEV_IRQ_EN
    if (bus.addr == A_CFG) begin
      rdata[0]      = ie;
      rdata[CW+7:8] = thr;
    end
`endif
  end

  assign bus.dout     = rdata;
  assign bus.tx_data  = mem[rd_ptr];
  assign bus.tx_valid = (count != '0);
endmodule

// File: tb/tb_out_dev_fifo.sv
// Directed bench for out_dev_fifo (WIDTH=32, DEPTH=8, NREG=2, ADDR_W=3).
// Map: 0,1 HOLD; 2 TX; 3 STATUS; 4 IRQCFG.
module tb_out_dev_fifo;
  localparam logic [2:0] A_H0 = 3'd0, A_H1 = 3'd1, A_TX = 3'd2, A_ST = 3'd3, A_CFG = 3'd4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  out_dev_fifo_if #(.WIDTH(32), .ADDR_W(3)) bus ();

`ifdef OUT_DEV_IRQ_EN
  logic irq;
  out_dev_fifo #(.WIDTH(32), .DEPTH(8), .NREG(2), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .irq(irq));
`else
  out_dev_fifo #(.WIDTH(32), .DEPTH(8), .NREG(2), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.en = 1'b1; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.addr = a; #1;
    d = bus.dout;
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    @(negedge clk); reset = 1'b0;
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0001_0000) begin failures++; $display("FAIL reset_status got=%h exp=00010000", d); end
    rd(A_H0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_hold0 got=%h exp=0", d); end
    rd(A_TX, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_txlast got=%h exp=0", d); end
  endtask

  task automatic test_hold();
    logic [31:0] d;
    wr(A_H0, 32'h1234_5678);
    wr(A_H1, 32'hCAFE_0001);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(A_H0, d);
    checks++;
    if (d !== 32'h1234_5678) begin failures++; $display("FAIL hold0 got=%h exp=12345678", d); end
    rd(A_H1, d);
    checks++;
    if (d !== 32'hCAFE_0001) begin failures++; $display("FAIL hold1 got=%h exp=cafe0001", d); end
    rd(3'd7, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", d); end
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0001_0000) begin failures++; $display("FAIL hold_status got=%h exp=00010000", d); end
`ifndef OUT_DEV_IRQ_EN
    wr(A_CFG, 32'hFFFF_FFFF);
    rd(A_CFG, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL cfg_absent got=%h exp=0", d); end
`endif
  endtask

  task automatic test_fifo_order();
    logic [31:0] d;
    logic [31:0] w [3];
    w[0] = 32'hA000_0011; w[1] = 32'hA000_0022; w[2] = 32'hA000_0033;
    for (int i = 0; i < 3; i++) wr(A_TX, w[i]);
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0000_0003) begin failures++; $display("FAIL order_status got=%h exp=00000003", d); end
    rd(A_TX, d);
    checks++;
    if (d !== w[2]) begin failures++; $display("FAIL order_txlast got=%h exp=%h", d, w[2]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== w[i]) begin
        failures++; $display("FAIL order_head%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, w[i]);
      end
      pop_one();
    end
    rd(A_ST, d);
    checks++;
    if (bus.tx_valid !== 1'b0 || d !== 32'h0001_0000) begin
      failures++; $display("FAIL order_empty got=%b/%h exp=0/00010000", bus.tx_valid, d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) wr(A_TX, 32'hB000_0000 + i);
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0006_0008) begin failures++; $display("FAIL ovf_status got=%h exp=00060008", d); end
    rd(A_TX, d);
    checks++;
    if (d !== 32'hB000_0007) begin failures++; $display("FAIL ovf_txlast got=%h exp=b0000007", d); end
    wr(A_ST, 32'h0004_0000);
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0002_0008) begin failures++; $display("FAIL ovf_clear got=%h exp=00020008", d); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.tx_data !== 32'hB000_0000 + i) begin
        failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus.tx_data, 32'hB000_0000 + i);
      end
      pop_one();
    end
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0001_0000) begin failures++; $display("FAIL ovf_dropped got=%h exp=00010000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'hC000_0000 + i);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.en = 1'b1; bus.addr = A_TX; bus.din = 32'hD000_0000 + i; bus.tx_ready = 1'b1;
      e = (i < 8) ? 32'hC000_0000 + i : 32'hD000_0000 + (i - 8);
      checks++;
      if (bus.tx_data !== e) begin failures++; $display("FAIL b2b_head%0d got=%h exp=%h", i, bus.tx_data, e); end
      @(posedge clk); #1;
    end
    bus.en = 1'b0; bus.tx_ready = 1'b0;
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0002_0008) begin failures++; $display("FAIL b2b_status got=%h exp=00020008", d); end
    for (int i = 2; i < 10; i++) begin
      checks++;
      if (bus.tx_data !== 32'hD000_0000 + i) begin
        failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, bus.tx_data, 32'hD000_0000 + i);
      end
      pop_one();
    end
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) wr(A_TX, 32'hE000_0000 + i);
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0000_0005) begin failures++; $display("FAIL rst5_status got=%h exp=00000005", d); end
    @(negedge clk);
    bus.addr = A_ST;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.dout !== 32'h0001_0000) begin
      failures++; $display("FAIL rst_async got=%b/%h exp=0/00010000", bus.tx_valid, bus.dout);
    end
    #2 reset = 1'b0;
    wr(A_TX, 32'hF000_0001);
    rd(A_ST, d);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'hF000_0001 || d !== 32'h0000_0001) begin
      failures++; $display("FAIL rst_first got=%b/%h/%h exp=1/f0000001/00000001", bus.tx_valid, bus.tx_data, d);
    end
    pop_one();
    checks++;
    if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_alone got=%b exp=0", bus.tx_valid); end
  endtask

`ifdef OUT_DEV_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    logic        ei [4];
    wr(A_CFG, 32'h0000_0201);
    rd(A_CFG, d);
    checks++;
    if (d !== 32'h0000_0201) begin failures++; $display("FAIL irq_cfg got=%h exp=00000201", d); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_empty got=%b exp=1", irq); end
    ei[0] = 1'b1; ei[1] = 1'b1; ei[2] = 1'b0; ei[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(A_TX, 32'h9000_0000 + i);
      checks++;
      if (irq !== ei[i]) begin failures++; $display("FAIL irq_push%0d got=%b exp=%b", i + 1, irq, ei[i]); end
    end
    ei[0] = 1'b0; ei[1] = 1'b1; ei[2] = 1'b1; ei[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_one();
      checks++;
      if (irq !== ei[i]) begin failures++; $display("FAIL irq_pop%0d got=%b exp=%b", i + 1, irq, ei[i]); end
      if (i == 1) begin
        rd(A_ST, d);
        checks++;
        if (d !== 32'h0008_0002) begin failures++; $display("FAIL irq_status got=%h exp=00080002", d); end
      end
    end
    wr(A_CFG, 32'h0000_0200);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_ie_clear got=%b exp=0", irq); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.addr = '0; bus.din = '0; bus.tx_ready = 1'b0;
    test_reset();
    test_hold();
    test_fifo_order();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef OUT_DEV_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
